// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned LAT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned line_width(input int unsigned word_size);
        return 4 * word_size;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of the arbiter; master = arbiter, slave = caches plus memory model.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16
);
    import mem_arbiter_pkg::*;

    localparam int unsigned LineW = line_width(WORD_SIZE);

    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [LineW-1:0]     i_rdata;
    logic                 i_ack;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [LineW-1:0]     d_wdata;
    logic [LineW-1:0]     d_rdata;
    logic                 d_ack;

    logic                 m_readM;
    logic                 m_writeM;
    logic [WORD_SIZE-1:0] m_addr;
    logic [LineW-1:0]     m_wdata;
    logic [LineW-1:0]     m_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_readM, m_writeM, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_readM, m_writeM, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select between I- and D-cache requests.
// MEM_ARB_RR_EN selects round-robin ties; otherwise D always beats I.
module mem_arbiter_pick (
    input  logic i_req_icache,
    input  logic i_req_dcache,
`ifdef MEM_ARB_RR_EN
    input  logic i_last_dcache,
`endif
    output logic o_grant_any,
    output logic o_grant_dcache
);

    always_comb begin
        o_grant_any = i_req_icache | i_req_dcache;
`ifdef MEM_ARB_RR_EN
        // Tie goes to whoever did not win last time.
        if (i_req_icache && i_req_dcache) begin
            o_grant_dcache = ~i_last_dcache;
        end else begin
            o_grant_dcache = i_req_dcache;
        end
`else
        o_grant_dcache = i_req_dcache;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the line-wide main-memory port between I-cache and D-cache, one access at a time.
// Define MEM_ARB_RR_EN for round-robin tie breaking instead of fixed D-over-I priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);

    localparam int unsigned              LineW     = line_width(WORD_SIZE);
    localparam logic [LAT_CNT_WIDTH-1:0] LastCnt   = LAT_CNT_WIDTH'(MEM_LATENCY - 1);
    localparam logic [WORD_SIZE-1:0]     AlignMask = ~WORD_SIZE'(3);

    state_e                   r_state;
    state_e                   w_state_next;
    logic [LAT_CNT_WIDTH-1:0] r_cnt;
    logic                     r_sel_d;
    logic [WORD_SIZE-1:0]     r_addr;
    logic [LineW-1:0]         r_wdata;
    logic [LineW-1:0]         r_i_rdata;
    logic [LineW-1:0]         r_d_rdata;
    logic                     r_readM;
    logic                     r_writeM;
    logic                     r_i_ack;
    logic                     r_d_ack;

    logic                     w_readM_next;
    logic                     w_writeM_next;
    logic                     w_i_ack_next;
    logic                     w_d_ack_next;
    logic                     w_grant_any;
    logic                     w_grant_d;
    logic                     w_grant;
    logic                     w_last_beat;
    logic                     w_d_write;
    logic [WORD_SIZE-1:0]     w_addr_sel;

    // r_sel_d doubles as the last-winner register in round-robin builds.
    mem_arbiter_pick u_pick (
        .i_req_icache  (bus.i_req),
        .i_req_dcache  (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .i_last_dcache (r_sel_d),
`endif
        .o_grant_any   (w_grant_any),
        .o_grant_dcache(w_grant_d)
    );

    assign w_grant     = (r_state == StIdle) && w_grant_any;
    assign w_last_beat = (r_state == StBusy) && (r_cnt == LastCnt);
    assign w_d_write   = w_grant_d && bus.d_we;
    assign w_addr_sel  = w_grant_d ? bus.d_addr : bus.i_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_grant_any) w_state_next = StBusy;
            StBusy:  if (r_cnt == LastCnt) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_readM_next  = 1'b0;
        w_writeM_next = 1'b0;
        w_i_ack_next  = 1'b0;
        w_d_ack_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_readM_next  = w_grant_any && !w_d_write;
                w_writeM_next = w_grant_any && w_d_write;
            end
            StBusy: begin
                if (w_last_beat) begin
                    w_i_ack_next = ~r_sel_d;
                    w_d_ack_next = r_sel_d;
                end else begin
                    w_readM_next  = r_readM;
                    w_writeM_next = r_writeM;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_sel_d   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_readM   <= 1'b0;
            r_writeM  <= 1'b0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
        end else begin
            r_readM  <= w_readM_next;
            r_writeM <= w_writeM_next;
            r_i_ack  <= w_i_ack_next;
            r_d_ack  <= w_d_ack_next;
            if (w_grant) begin
                r_sel_d <= w_grant_d;
                r_addr  <= w_addr_sel & AlignMask;
                r_cnt   <= '0;
                if (w_grant_d) r_wdata <= bus.d_wdata;
            end else if (r_state == StBusy) begin
                r_cnt <= r_cnt + LAT_CNT_WIDTH'(1);
            end
            if (w_last_beat && r_readM) begin
                if (r_sel_d) r_d_rdata <= bus.m_rdata;
                else         r_i_rdata <= bus.m_rdata;
            end
        end
    end

    assign bus.m_readM  = r_readM;
    assign bus.m_writeM = r_writeM;
    assign bus.m_addr   = r_addr;
    assign bus.m_wdata  = r_wdata;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.i_ack    = r_i_ack;
    assign bus.d_ack    = r_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed and random traffic.
module tb_mem_arbiter;

    localparam int unsigned L = 4;

    logic clk;
    logic reset_n;

    mem_arbiter_if #(.WORD_SIZE(16)) bus ();

    mem_arbiter #(
        .WORD_SIZE  (16),
        .MEM_LATENCY(L)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // Transaction-level model: an access granted at edge g strobes for edges g..g+L-1,
    // acks after edge g+L and the arbiter samples requests again at edge g+L+2.
    bit          m_ok = 0;
    bit          m_active = 0;
    bit          m_sel_d = 0;
    bit          m_we = 0;
    bit          m_last_d = 0;
    int          m_g = 0;
    int          m_free = 0;
    logic        e_read = 0, e_write = 0, e_iack = 0, e_dack = 0;
    logic [15:0] e_addr = '0;
    logic [63:0] e_wdata = '0, e_irdata = '0, e_drdata = '0;

    always @(posedge clk) begin : model
        int off;
        bit sel;
        cyc++;
        if (!reset_n) begin
            m_ok = 1; m_active = 0; m_last_d = 0; m_free = cyc + 1;
            e_read = 0; e_write = 0; e_iack = 0; e_dack = 0;
            e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
        end else begin
            e_iack = 0;
            e_dack = 0;
            if (m_active) begin
                off = cyc - m_g;
                if (off == int'(L)) begin
                    e_read  = 0;
                    e_write = 0;
                    if (!m_we) begin
                        if (m_sel_d) e_drdata = bus.m_rdata;
                        else         e_irdata = bus.m_rdata;
                    end
                    if (m_sel_d) e_dack = 1;
                    else         e_iack = 1;
                end else if (off == int'(L) + 1) begin
                    m_active = 0;
                end
            end
            if (!m_active && cyc >= m_free && (bus.i_req || bus.d_req)) begin
`ifdef MEM_ARB_RR_EN
                if (bus.i_req && bus.d_req) sel = !m_last_d;
                else                        sel = bus.d_req;
`else
                sel = bus.d_req;
`endif
                m_last_d = sel;
                m_sel_d  = sel;
                m_we     = sel && bus.d_we;
                m_active = 1;
                m_g      = cyc;
                m_free   = cyc + int'(L) + 2;
                e_addr   = (sel ? bus.d_addr : bus.i_addr) & 16'hFFFC;
                if (sel) e_wdata = bus.d_wdata;
                e_read   = !m_we;
                e_write  = m_we;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk1("i_ack", bus.i_ack, e_iack);
            chk1("d_ack", bus.d_ack, e_dack);
            chk1("m_readM", bus.m_readM, e_read);
            chk1("m_writeM", bus.m_writeM, e_write);
            chk("m_addr", 64'(bus.m_addr), 64'(e_addr));
            chk("m_wdata", bus.m_wdata, e_wdata);
            chk("i_rdata", bus.i_rdata, e_irdata);
            chk("d_rdata", bus.d_rdata, e_drdata);
            chk1("ack_excl", bus.i_ack & bus.d_ack, 1'b0);
            chk1("strobe_excl", bus.m_readM & bus.m_writeM, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.m_rdata = {$urandom, $urandom};
    endtask

    // One isolated access with literal timing checks; drop_at>0 deasserts req mid-access.
    task automatic single_txn(input bit is_d, input bit we, input logic [15:0] addr,
                              input logic [63:0] wd, input int drop_at, input string tag);
        logic [63:0] snap;
        logic        ack;
        snap = '0;
        step();
        if (is_d) begin
            bus.d_addr = addr; bus.d_we = we; bus.d_wdata = wd; bus.d_req = 1;
        end else begin
            bus.i_addr = addr; bus.i_req = 1;
        end
        for (int k = 1; k <= int'(L) + 2; k++) begin
            step();
            ack = is_d ? bus.d_ack : bus.i_ack;
            chk1({tag, "_rd"}, bus.m_readM, (k <= int'(L)) && !(is_d && we));
            chk1({tag, "_wr"}, bus.m_writeM, (k <= int'(L)) && is_d && we);
            chk1({tag, "_ack"}, ack, k == int'(L) + 1);
            if (k == 1) begin
                chk({tag, "_addr"}, 64'(bus.m_addr), 64'(addr & 16'hFFFC));
                if (is_d && we) chk({tag, "_wdata"}, bus.m_wdata, wd);
            end
            if (k == int'(L)) snap = bus.m_rdata;
            if (k == drop_at || k == int'(L) + 1) begin
                bus.i_req = 0;
                bus.d_req = 0;
            end
            if (k == int'(L) + 1 && !(is_d && we))
                chk({tag, "_rdata"}, is_d ? bus.d_rdata : bus.i_rdata, snap);
        end
    endtask

    task automatic drive_i(input int n);
        bit acked;
        for (int t = 0; t < n; t++) begin
            acked = 0;
            repeat ($urandom_range(1, 4)) step();
            bus.i_addr = 16'($urandom);
            bus.i_req  = 1;
            for (int k = 0; k < 80 && !acked; k++) begin
                step();
                if (bus.i_ack) acked = 1;
            end
            bus.i_req = 0;
            chk1("i_ack_timeout", acked, 1'b1);
        end
    endtask

    task automatic drive_d(input int n);
        bit acked;
        for (int t = 0; t < n; t++) begin
            acked = 0;
            repeat ($urandom_range(2, 6)) step();
            bus.d_addr  = 16'($urandom);
            bus.d_we    = 1'($urandom);
            bus.d_wdata = {$urandom, $urandom};
            bus.d_req   = 1;
            for (int k = 0; k < 80 && !acked; k++) begin
                step();
                if (bus.d_ack) acked = 1;
            end
            bus.d_req = 0;
            chk1("d_ack_timeout", acked, 1'b1);
        end
    endtask

    initial begin
        logic [3:0] order;
        int         n;
        bit         i_again, d_again;

        reset_n     = 0;
        bus.i_req   = 0; bus.i_addr = '0;
        bus.d_req   = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0;

        // Reset held for two cycles: everything zero.
        step();
        step();
        chk1("rst_iack", bus.i_ack, 1'b0);
        chk1("rst_dack", bus.d_ack, 1'b0);
        chk1("rst_rd", bus.m_readM, 1'b0);
        chk1("rst_wr", bus.m_writeM, 1'b0);
        chk("rst_addr", 64'(bus.m_addr), 64'd0);
        chk("rst_irdata", bus.i_rdata, 64'd0);
        chk("rst_drdata", bus.d_rdata, 64'd0);
        reset_n = 1;
        repeat (2) step();

        // Plain I-cache read.
        single_txn(0, 0, 16'h0047, 64'd0, 0, "iread");
        chk("iread_line_addr", 64'(bus.m_addr), 64'h0044);
        repeat (2) step();

        // Collision: D write served first, I read follows.
        step();
        bus.i_addr = 16'h0100; bus.i_req = 1;
        bus.d_addr = 16'h0010; bus.d_we = 1; bus.d_wdata = 64'h0004_0003_0002_0001;
        bus.d_req  = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk1("col_wr", bus.m_writeM, k >= 1 && k <= 4);
            chk1("col_dack", bus.d_ack, k == 5);
            chk1("col_rd", bus.m_readM, k >= 7 && k <= 10);
            chk1("col_iack", bus.i_ack, k == 11);
            if (k == 1) begin
                chk("col_daddr", 64'(bus.m_addr), 64'h0010);
                chk("col_wdata", bus.m_wdata, 64'h0004_0003_0002_0001);
            end
            if (k == 7) chk("col_iaddr", 64'(bus.m_addr), 64'h0100);
            if (bus.d_ack) bus.d_req = 0;
            if (bus.i_ack) bus.i_req = 0;
        end
        bus.d_we = 0;
        repeat (2) step();

        // Both sides re-request right after each completion.
        order = '0; n = 0; i_again = 0; d_again = 0;
        step();
        bus.i_addr = 16'h0200; bus.d_addr = 16'h0300; bus.d_we = 0;
        bus.i_req = 1; bus.d_req = 1;
        for (int k = 0; k < 40 && n < 4; k++) begin
            step();
            if (i_again) begin bus.i_req = 1; i_again = 0; end
            if (d_again) begin bus.d_req = 1; d_again = 0; end
            if (bus.d_ack) begin order[n[1:0]] = 1'b1; n++; bus.d_req = 0; d_again = 1; end
            if (bus.i_ack) begin order[n[1:0]] = 1'b0; n++; bus.i_req = 0; i_again = 1; end
        end
        bus.i_req = 0; bus.d_req = 0;
        repeat (L + 3) step();
        chk("pri_count", 64'(n), 64'd4);
`ifdef MEM_ARB_RR_EN
        chk("pri_order", 64'(order), 64'(4'b0101));
`else
        chk("pri_order", 64'(order), 64'(4'b1111));
`endif

        // Reset during the second BUSY cycle aborts the access.
        step();
        bus.i_addr = 16'h2222; bus.i_req = 1;
        step();
        step();
        chk1("rstm_busy", bus.m_readM, 1'b1);
        reset_n = 0; bus.i_req = 0;
        step();
        chk1("rstm_rd", bus.m_readM, 1'b0);
        reset_n = 1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk1("rstm_noack_i", bus.i_ack, 1'b0);
            chk1("rstm_noack_d", bus.d_ack, 1'b0);
            chk1("rstm_idle", bus.m_readM, 1'b0);
        end
        single_txn(0, 0, 16'h3333, 64'd0, 0, "reissue");
        repeat (2) step();

        // Mid-access deassert, then D read and D write.
        single_txn(0, 0, 16'h1235, 64'd0, 2, "middrop");
        repeat (2) step();
        single_txn(1, 0, 16'h0ABC, 64'd0, 0, "dread");
        repeat (2) step();
        single_txn(1, 1, 16'h0FFF, 64'hDEAD_BEEF_0123_4567, 0, "dwrite");
        bus.d_we = 0;
        repeat (2) step();

        // Random traffic from both caches.
        fork
            drive_i(50);
            drive_d(50);
        join
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
